// File: rtl/easyaxi_pkg.sv
// Shared constants and helpers for the easyaxi outstanding-slot allocator and
// the per-ID order tracker that sits downstream of it.
package easyaxi_pkg;

  localparam int OST_DEPTH_DEF = 16;
  localparam int ID_WIDTH_DEF  = 4;

  // Slot pointer width; never narrower than one bit so a 1- or 2-deep build
  // still has a real pointer bus.
  function automatic int ptr_width_f(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/easyaxi_ost_alloc_if.sv
// Request/response handshake bundle for easyaxi_ost_alloc.
// slave  : the allocator's view (accepts up requests, drives dn, takes releases).
// master : the surrounding logic's view (issues requests, consumes dn, releases).
interface easyaxi_ost_alloc_if #(
  parameter int ID_WIDTH  = 4,
  parameter int PTR_WIDTH = 4
);
  logic                 up_valid;
  logic                 up_ready;
  logic [ID_WIDTH-1:0]  up_id;
  logic                 dn_valid;
  logic                 dn_ready;
  logic [ID_WIDTH-1:0]  dn_id;
  logic [PTR_WIDTH-1:0] dn_ptr;
  logic                 rel_valid;
  logic [PTR_WIDTH-1:0] rel_ptr;

  modport slave (
    input  up_valid, up_id, dn_ready, rel_valid, rel_ptr,
    output up_ready, dn_valid, dn_id, dn_ptr
  );

  modport master (
    output up_valid, up_id, dn_ready, rel_valid, rel_ptr,
    input  up_ready, dn_valid, dn_id, dn_ptr
  );
endinterface

// File: rtl/easyaxi_prio_enc.sv
// Lowest-index-first priority encoder. Used on the inverted busy bitmap to
// find the first free slot.
module easyaxi_prio_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/easyaxi_ost_alloc.sv
// Outstanding-slot allocator. Hands each accepted request the lowest free slot
// pointer, forwards it through one register stage, and frees the slot when the
// order tracker reports the last response beat for it.
// Optional release checker: define EASYAXI_OST_ALLOC_CHK_EN to add the sticky
// rel_err flag for releases that hit a free or out-of-range slot.
module easyaxi_ost_alloc
  import easyaxi_pkg::*;
#(
  parameter int  OST_DEPTH = OST_DEPTH_DEF,
  parameter int  ID_WIDTH  = ID_WIDTH_DEF,
  localparam int PTR_WIDTH = ptr_width_f(OST_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  easyaxi_ost_alloc_if.slave   bus,
  output logic [OST_DEPTH-1:0] slot_busy,
  output logic [PTR_WIDTH:0]   ost_cnt,
  output logic                 full,
  output logic                 empty
`ifdef EASYAXI_OST_ALLOC_CHK_EN
  ,
  output logic                 rel_err
`endif
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(OST_DEPTH);

  logic                 stage_free;
  logic                 accept;
  logic                 rel_hit;
  logic [PTR_WIDTH-1:0] free_ptr;
  logic                 free_any;
  logic [OST_DEPTH-1:0] alloc_mask;
  logic [OST_DEPTH-1:0] rel_mask;

  logic                 dn_valid_q;
  logic [ID_WIDTH-1:0]  dn_id_q;
  logic [PTR_WIDTH-1:0] dn_ptr_q;

  // Allocation always looks at the registered bitmap, so a slot released this
  // cycle only becomes visible next cycle.
  easyaxi_prio_enc #(
    .WIDTH (OST_DEPTH),
    .IDX_W (PTR_WIDTH)
  ) u_prio_enc (
    .req (~slot_busy),
    .idx (free_ptr),
    .any (free_any)
  );

  assign full  = (ost_cnt == DEPTH_C);
  assign empty = (ost_cnt == '0);

  assign stage_free   = ~dn_valid_q | bus.dn_ready;
  // free_any is redundant with ~full while the count tracks the bitmap; kept
  // so a corrupted count can never allocate an already-busy slot.
  assign bus.up_ready = stage_free & ~full & free_any;
  assign accept       = bus.up_valid & bus.up_ready;

  assign bus.dn_valid = dn_valid_q;
  assign bus.dn_id    = dn_id_q;
  assign bus.dn_ptr   = dn_ptr_q;

  // Qualify the release: in range and currently busy, otherwise it is ignored.
  always_comb begin
    rel_hit = 1'b0;
    if (bus.rel_valid && ({1'b0, bus.rel_ptr} < DEPTH_C)) begin
      rel_hit = slot_busy[bus.rel_ptr];
    end
  end

  // One-hot set/clear masks; allocation and release can never target the same
  // slot because one must be free and the other busy.
  always_comb begin
    alloc_mask = '0;
    rel_mask   = '0;
    if (accept)  alloc_mask = OST_DEPTH'(1) << free_ptr;
    if (rel_hit) rel_mask   = OST_DEPTH'(1) << bus.rel_ptr;
  end

  // Forwarding register: load on accept, hold while stalled, drop after handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid_q <= 1'b0;
      dn_id_q    <= '0;
      dn_ptr_q   <= '0;
    end else if (accept) begin
      dn_valid_q <= 1'b1;
      dn_id_q    <= bus.up_id;
      dn_ptr_q   <= free_ptr;
    end else if (bus.dn_ready) begin
      dn_valid_q <= 1'b0;
    end
  end

  // Busy bitmap and matching outstanding count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_busy <= '0;
      ost_cnt   <= '0;
    end else begin
      slot_busy <= (slot_busy | alloc_mask) & ~rel_mask;
      if (accept && !rel_hit) begin
        ost_cnt <= ost_cnt + 1'b1;
      end else if (rel_hit && !accept) begin
        ost_cnt <= ost_cnt - 1'b1;
      end
    end
  end

`ifdef EASYAXI_OST_ALLOC_CHK_EN
  // Sticky flag for any release that did not free a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_err <= 1'b0;
    end else if (bus.rel_valid && !rel_hit) begin
      rel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_easyaxi_ost_alloc.sv
// Directed bench for easyaxi_ost_alloc. Stimulus pushes the expected {id,ptr}
// of every accepted request; a monitor pops and compares on each dn handshake.
// Builds with or without EASYAXI_OST_ALLOC_CHK_EN.
module tb_easyaxi_ost_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] slot_busy;
  logic [4:0]  ost_cnt;
  logic        full;
  logic        empty;
`ifdef EASYAXI_OST_ALLOC_CHK_EN
  logic        rel_err;
`endif

  int vecs = 0;
  int errs = 0;
  logic [7:0] sb_q[$];

  easyaxi_ost_alloc_if #(.ID_WIDTH(4), .PTR_WIDTH(4)) bus ();

  easyaxi_ost_alloc #(.OST_DEPTH(16), .ID_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .slot_busy (slot_busy),
    .ost_cnt   (ost_cnt),
    .full      (full),
    .empty     (empty)
`ifdef EASYAXI_OST_ALLOC_CHK_EN
    ,
    .rel_err   (rel_err)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every dn handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (!rst && bus.dn_valid && bus.dn_ready) begin
      vecs++;
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL dn_unexpected: got id=%0d ptr=%0d, expected no transfer", bus.dn_id, bus.dn_ptr);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        if ({bus.dn_id, bus.dn_ptr} !== e) begin
          errs++;
          $display("FAIL dn_xfer: got id=%0d ptr=%0d, expected id=%0d ptr=%0d",
                   bus.dn_id, bus.dn_ptr, e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request, wait (bounded) for up_ready, record the expectation.
  // up_valid is left high; the caller drops it.
  task automatic issue(input logic [3:0] id, input logic [3:0] ptr);
    int n = 0;
    bus.up_valid = 1'b1;
    bus.up_id    = id;
    @(negedge clk);
    while (!bus.up_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.up_ready) begin
      vecs++;
      errs++;
      $display("FAIL issue_timeout: got up_ready=0, expected 1 for id=%0d", id);
    end else begin
      sb_q.push_back({id, ptr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_slot(input logic [3:0] p);
    bus.rel_valid = 1'b1;
    bus.rel_ptr   = p;
    @(posedge clk);
    #1;
    bus.rel_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.up_valid  = 1'b0;
    bus.up_id     = '0;
    bus.dn_ready  = 1'b1;
    bus.rel_valid = 1'b0;
    bus.rel_ptr   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset values, then three back-to-back requests
    @(negedge clk);
    chk("rst_dn_valid", 32'(bus.dn_valid), 32'd0);
    chk("rst_dn_id",    32'(bus.dn_id),    32'd0);
    chk("rst_dn_ptr",   32'(bus.dn_ptr),   32'd0);
    chk("rst_busy",     32'(slot_busy),    32'd0);
    chk("rst_cnt",      32'(ost_cnt),      32'd0);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_up_ready", 32'(bus.up_ready), 32'd1);
`ifdef EASYAXI_OST_ALLOC_CHK_EN
    chk("rst_rel_err",  32'(rel_err),      32'd0);
`endif
    @(posedge clk); #1;
    issue(4'd5, 4'd0);
    issue(4'd2, 4'd1);
    issue(4'd5, 4'd2);
    bus.up_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy", 32'(slot_busy), 32'h0007);
    chk("t1_cnt",  32'(ost_cnt),   32'd3);
    chk("t1_empty", 32'(empty),    32'd0);
    @(posedge clk); #1;

    // 2: fill, stall on full, release slot 9, reuse it
    for (int i = 3; i < 16; i++) issue(4'(i), 4'(i));
    bus.up_id = 4'd7;
    @(negedge clk);
    chk("t2_full",     32'(full),         32'd1);
    chk("t2_up_ready", 32'(bus.up_ready), 32'd0);
    chk("t2_cnt",      32'(ost_cnt),      32'd16);
    @(posedge clk); #1;
    bus.rel_valid = 1'b1;
    bus.rel_ptr   = 4'd9;
    @(negedge clk);
    chk("t2_ready_same_cycle", 32'(bus.up_ready), 32'd0);
    @(posedge clk); #1;
    bus.rel_valid = 1'b0;
    @(negedge clk);
    chk("t2_ready_after_rel", 32'(bus.up_ready), 32'd1);
    chk("t2_busy_after_rel",  32'(slot_busy),    32'hFDFF);
    sb_q.push_back({4'd7, 4'd9});
    @(posedge clk); #1;
    bus.up_valid = 1'b0;
    @(negedge clk);
    chk("t2_cnt_refull", 32'(ost_cnt),   32'd16);
    chk("t2_busy_refull", 32'(slot_busy), 32'hFFFF);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) release_slot(4'(i));
    @(negedge clk);
    chk("t2_drain_cnt",   32'(ost_cnt), 32'd0);
    chk("t2_drain_empty", 32'(empty),   32'd1);
    @(posedge clk); #1;

    // 3: downstream stall holds the stage and blocks further allocation
    bus.dn_ready = 1'b0;
    issue(4'd3, 4'd0);
    bus.up_id = 4'd6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_dn_valid", 32'(bus.dn_valid), 32'd1);
      chk("t3_dn_id",    32'(bus.dn_id),    32'd3);
      chk("t3_dn_ptr",   32'(bus.dn_ptr),   32'd0);
      chk("t3_up_ready", 32'(bus.up_ready), 32'd0);
      chk("t3_cnt",      32'(ost_cnt),      32'd1);
      @(posedge clk); #1;
    end
    bus.up_valid = 1'b0;
    bus.dn_ready = 1'b1;
    @(posedge clk); #1;
    release_slot(4'd0);

    // 4: allocate and release in the same cycle
    for (int i = 0; i < 4; i++) issue(4'(i + 1), 4'(i));
    bus.up_id     = 4'd8;
    bus.rel_valid = 1'b1;
    bus.rel_ptr   = 4'd1;
    sb_q.push_back({4'd8, 4'd4});
    @(posedge clk); #1;
    bus.up_valid  = 1'b0;
    bus.rel_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(slot_busy), 32'h001D);
    chk("t4_cnt",  32'(ost_cnt),   32'd4);
    @(posedge clk); #1;

    // 5: release of a free slot is ignored
    release_slot(4'd7);
    @(negedge clk);
    chk("t5_busy", 32'(slot_busy), 32'h001D);
    chk("t5_cnt",  32'(ost_cnt),   32'd4);
`ifdef EASYAXI_OST_ALLOC_CHK_EN
    chk("t5_rel_err", 32'(rel_err), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_rel_err_sticky", 32'(rel_err), 32'd1);
`endif
    @(posedge clk); #1;

    // 6: reset mid-operation with 5 busy and dn_valid held high
    bus.dn_ready = 1'b0;
    issue(4'd9, 4'd1);
    bus.up_valid = 1'b0;
    @(negedge clk);
    chk("t6_pre_cnt",      32'(ost_cnt),      32'd5);
    chk("t6_pre_dn_valid", 32'(bus.dn_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_dn_valid", 32'(bus.dn_valid), 32'd0);
    chk("t6_rst_dn_id",    32'(bus.dn_id),    32'd0);
    chk("t6_rst_dn_ptr",   32'(bus.dn_ptr),   32'd0);
    chk("t6_rst_busy",     32'(slot_busy),    32'd0);
    chk("t6_rst_cnt",      32'(ost_cnt),      32'd0);
    chk("t6_rst_full",     32'(full),         32'd0);
    chk("t6_rst_empty",    32'(empty),        32'd1);
`ifdef EASYAXI_OST_ALLOC_CHK_EN
    chk("t6_rst_rel_err",  32'(rel_err),      32'd0);
`endif
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.dn_ready = 1'b1;
    issue(4'd2, 4'd0);
    bus.up_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("end_cnt",      32'(ost_cnt),     32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
